mfp_ahb_loader_arbiter: RTL and testbench
=========================================

# mfp_ahb_loader_arbiter

Two-master AHB-Lite arbiter that shares the single `mfp_ahb` slave fabric between the MIPS core (CPU master) and the UART S-record loader bridge (LDR master). It replaces a plain combinational select with transfer-boundary-safe handover: the loader preempts the CPU, and the CPU's in-flight address phase is parked and replayed on handback, so no transfer is lost or duplicated. It sits between both masters and the `mfp_ahb` slave port.

## Interface
- No parameters; widths come from the shared package.
- `HCLK  in  1`: system clock.
- `HRESET  in  1`: asynchronous reset, active-high.
- `cpu_HADDR[31:0], cpu_HTRANS[1:0], cpu_HWRITE, cpu_HSIZE[2:0], cpu_HBURST[2:0], cpu_HPROT[3:0], cpu_HMASTLOCK, cpu_HWDATA[31:0]  in`: CPU master request.
- `cpu_HRDATA  out  32`, `cpu_HREADY  out  1`, `cpu_HRESP  out  1`: CPU response.
- `ldr_req  in  1`: loader wants the bus (driven from the parser's in-progress flag).
- `ldr_HADDR[31:0], ldr_HTRANS[1:0], ldr_HWRITE, ldr_HSIZE[2:0], ldr_HWDATA[31:0]  in`: loader request. HBURST is SINGLE, HPROT 4'b0011, and HMASTLOCK 0 are implied.
- `ldr_HREADY  out  1`: loader stall/accept.
- `s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HBURST, s_HPROT, s_HMASTLOCK, s_HWDATA  out`: to slave fabric.
- `s_HRDATA  in  32`, `s_HREADY  in  1`, `s_HRESP  in  1`: from slave fabric.
- `ldr_granted  out  1`: high while LDR owns the address phase. Reset value 0.

## Operation
- Registered state:
  - `gnt`: address-phase owner.
  - `dph`: data-phase owner.
  - `state`: one of CPU_OWN, LDR_OWN, REPLAY.
  - Park register: `park_valid` plus the full CPU address-phase bundle.
- Address mux:
  - CPU_OWN: live CPU signals.
  - LDR_OWN: loader signals.
  - REPLAY: park register.
- Write-data mux: `s_HWDATA` is taken from the `dph` owner.
- Response routing:
  - `s_HRDATA` goes to both masters.
  - `s_HRESP` goes to the `dph` owner only; the other master sees 0.
- Transitions:
  - CPU_OWN → LDR_OWN: at an edge with `s_HREADY`=1 and `ldr_req`=1.
    - Also requires no CPU lock (see Configuration).
    - If the live CPU `HTRANS` is NONSEQ/SEQ at that edge, its address bundle is the one being forwarded, so nothing is parked.
  - First LDR_OWN cycle:
    - The CPU data phase completes through `cpu_HREADY`=`s_HREADY`.
    - If `cpu_HTRANS` is NONSEQ/SEQ at an edge with `s_HREADY`=1 in this cycle, the CPU bundle is captured into the park register and `park_valid` is set.
  - Rest of LDR_OWN: `cpu_HREADY`=0, so the CPU waits in the data phase of the parked transfer with HWDATA held.
  - LDR_OWN → REPLAY: at an edge with `s_HREADY`=1, `ldr_req`=0 and `ldr_HTRANS`=IDLE, when `park_valid`=1.
  - LDR_OWN → CPU_OWN: same condition, when `park_valid`=0.
  - REPLAY:
    - The parked bundle is driven to the slave; `cpu_HREADY`=0.
    - At an edge with `s_HREADY`=1 → CPU_OWN and `park_valid` clears.
    - The next cycle completes the parked data phase with live CPU HWDATA, while the live CPU address goes out as the next address phase.
- Ready routing:
  - `ldr_HREADY` = `s_HREADY` when `gnt`=LDR or `dph`=LDR, else 0.
  - `cpu_HREADY` = `s_HREADY` in CPU_OWN and in the first LDR_OWN cycle, else 0.
- `dph` <= `gnt`-source on each edge with `s_HREADY`=1.
- Simultaneous `ldr_req` rise and a CPU burst SEQ beat: the loader wins. The burst is broken, and the replayed beat is sent with `HTRANS` forced from SEQ to NONSEQ.
- Asynchronous reset, any time:
  - Goes to CPU_OWN with `gnt`=`dph`=CPU and `park_valid`=0.
  - Any in-flight transfer is abandoned.

## Timing
- Zero-cycle combinational path from master to slave signals.
- Handover to the loader: the first loader address appears 1 cycle after the qualifying edge.
- Handback costs exactly 1 REPLAY cycle when a transfer is parked, 0 otherwise.
- CPU stall: equals the number of LDR_OWN cycles plus REPLAY wait states.

## Configuration
- `MFP_ARB_LOCK_EN` defined:
  - CPU_OWN → LDR_OWN is additionally blocked while `cpu_HMASTLOCK`=1 on the live address phase.
  - `s_HMASTLOCK` is forwarded from the owner.
- Undefined:
  - `cpu_HMASTLOCK` is ignored for arbitration.
  - `s_HMASTLOCK` is tied to 0.

## Structure
- Shared package `mfp_ahb_arb_pkg`:
  - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ).
  - State enum.
  - Address-bundle struct (HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK).
  - Loader default HPROT/HBURST constants.
- One sub-module: `mfp_ahb_addr_park`, the park register with load/clear and SEQ→NONSEQ rewrite.

## Test plan
- Idle loader; the CPU writes 0x1234_5678 to 0x0000_0010 → passes through untouched; `ldr_granted`=0 throughout.
- `ldr_req` rises during a CPU NONSEQ read of 0x0000_0040 → that read completes; the CPU's next address 0x0000_0044 is parked; loader byte write to 0x0000_0100 goes out next.
- Loader finishes (`ldr_req`=0, HTRANS IDLE) → 1 REPLAY cycle presents 0x0000_0044; the CPU gets correct read data; no transfer is duplicated.
- Slave inserts 3 wait states on the handover cycle → the park capture and loader address wait until `s_HREADY`=1.
- With `MFP_ARB_LOCK_EN` set and `cpu_HMASTLOCK`=1 for 4 transfers → the loader is held off until the lock drops; without the macro → the loader is granted immediately.
- `HRESET` pulse in mid LDR_OWN with `park_valid`=1 → `ldr_granted`=0 and `park_valid`=0; the next cycle forwards live CPU signals.

Source files
------------

// File: rtl/mfp_ahb_arb_pkg.sv
// mfp_ahb_arb_pkg: shared AHB encodings, arbiter state and address-bundle types
package mfp_ahb_arb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] LDR_HBURST    = 3'b000;
  localparam logic [3:0] LDR_HPROT     = 4'b0011;
  typedef enum logic [1:0] {CPU_OWN, LDR_OWN, REPLAY} arb_state_t;
  typedef enum logic {M_CPU, M_LDR} master_t;
  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
  } addr_bundle_t;
  function automatic logic [1:0] seq_to_nonseq(input logic [1:0] t);
    return (t == HTRANS_SEQ) ? HTRANS_NONSEQ : t;
  endfunction
endpackage

// File: rtl/mfp_ahb_addr_park.sv
// mfp_ahb_addr_park: holds a preempted CPU address phase for replay; a SEQ beat becomes NONSEQ since its burst is broken
module mfp_ahb_addr_park
  import mfp_ahb_arb_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  addr_bundle_t d,
  output addr_bundle_t q,
  output logic         valid
);
  // capture on load, drop validity on clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      q        <= d;
      q.htrans <= seq_to_nonseq(d.htrans);
    end else if (clear) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/mfp_ahb_loader_arbiter.sv
// mfp_ahb_loader_arbiter: CPU/loader AHB-Lite arbiter with park-and-replay handover; MFP_ARB_LOCK_EN honours CPU HMASTLOCK
module mfp_ahb_loader_arbiter
  import mfp_ahb_arb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] cpu_HADDR,
  input  logic [1:0]  cpu_HTRANS,
  input  logic        cpu_HWRITE,
  input  logic [2:0]  cpu_HSIZE,
  input  logic [2:0]  cpu_HBURST,
  input  logic [3:0]  cpu_HPROT,
  input  logic        cpu_HMASTLOCK,
  input  logic [31:0] cpu_HWDATA,
  output logic [31:0] cpu_HRDATA,
  output logic        cpu_HREADY,
  output logic        cpu_HRESP,
  input  logic        ldr_req,
  input  logic [31:0] ldr_HADDR,
  input  logic [1:0]  ldr_HTRANS,
  input  logic        ldr_HWRITE,
  input  logic [2:0]  ldr_HSIZE,
  input  logic [31:0] ldr_HWDATA,
  output logic        ldr_HREADY,
  output logic [31:0] s_HADDR,
  output logic [1:0]  s_HTRANS,
  output logic        s_HWRITE,
  output logic [2:0]  s_HSIZE,
  output logic [2:0]  s_HBURST,
  output logic [3:0]  s_HPROT,
  output logic        s_HMASTLOCK,
  output logic [31:0] s_HWDATA,
  input  logic [31:0] s_HRDATA,
  input  logic        s_HREADY,
  input  logic        s_HRESP,
  output logic        ldr_granted
);
`ifdef MFP_ARB_LOCK_EN
  localparam logic lock_en = 1'b1;
`else
  localparam logic lock_en = 1'b0;
`endif
  arb_state_t   state;
  master_t      gnt, dph;
  logic         first, park_valid, park_load, park_clear;
  addr_bundle_t cpu_b, ldr_b, park_q, abus;
  assign cpu_b = {cpu_HADDR, cpu_HTRANS, cpu_HWRITE, cpu_HSIZE, cpu_HBURST, cpu_HPROT, cpu_HMASTLOCK};
  assign ldr_b = {ldr_HADDR, ldr_HTRANS, ldr_HWRITE, ldr_HSIZE, LDR_HBURST, LDR_HPROT, 1'b0};
  assign park_load  = (state == LDR_OWN) & first & s_HREADY & cpu_HTRANS[1];
  assign park_clear = (state == REPLAY) & s_HREADY;
  mfp_ahb_addr_park u_park (
    .clk   (HCLK),
    .rst   (HRESET),
    .load  (park_load),
    .clear (park_clear),
    .d     (cpu_b),
    .q     (park_q),
    .valid (park_valid)
  );
  // address-phase source follows the arbiter state
  always_comb begin
    abus = (state == LDR_OWN) ? ldr_b : (state == REPLAY) ? park_q : cpu_b;
  end
  assign s_HADDR     = abus.haddr;
  assign s_HTRANS    = abus.htrans;
  assign s_HWRITE    = abus.hwrite;
  assign s_HSIZE     = abus.hsize;
  assign s_HBURST    = abus.hburst;
  assign s_HPROT     = abus.hprot;
  assign s_HMASTLOCK = lock_en & abus.hmastlock;
  assign s_HWDATA    = (dph == M_LDR) ? ldr_HWDATA : cpu_HWDATA;
  assign cpu_HRDATA  = s_HRDATA;
  assign cpu_HRESP   = (dph == M_CPU) & s_HRESP;
  assign cpu_HREADY  = ((state == CPU_OWN) | ((state == LDR_OWN) & first)) & s_HREADY;
  assign ldr_HREADY  = ((gnt == M_LDR) | (dph == M_LDR)) & s_HREADY;
  assign ldr_granted = (gnt == M_LDR);
  // ownership FSM; every move happens only on an accepted transfer boundary
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      state <= CPU_OWN;
      gnt   <= M_CPU;
      dph   <= M_CPU;
      first <= 1'b0;
    end else if (s_HREADY) begin
      dph   <= gnt;
      first <= 1'b0;
      case (state)
        CPU_OWN:
          if (ldr_req & ~(lock_en & cpu_HMASTLOCK)) begin
            state <= LDR_OWN;
            gnt   <= M_LDR;
            first <= 1'b1;
          end
        LDR_OWN:
          if (~ldr_req & (ldr_HTRANS == HTRANS_IDLE)) begin
            state <= (park_valid | park_load) ? REPLAY : CPU_OWN;
            gnt   <= M_CPU;
          end
        default: state <= CPU_OWN;
      endcase
    end
endmodule

// File: tb/tb_mfp_ahb_loader_arbiter.sv
// tb_mfp_ahb_loader_arbiter: directed self-checking bench for the loader/CPU arbiter
module tb_mfp_ahb_loader_arbiter;
`ifdef MFP_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic        HCLK, HRESET;
  logic [31:0] cpu_HADDR, cpu_HWDATA, cpu_HRDATA;
  logic [1:0]  cpu_HTRANS;
  logic        cpu_HWRITE, cpu_HMASTLOCK, cpu_HREADY, cpu_HRESP;
  logic [2:0]  cpu_HSIZE, cpu_HBURST;
  logic [3:0]  cpu_HPROT;
  logic        ldr_req, ldr_HWRITE, ldr_HREADY, ldr_granted;
  logic [31:0] ldr_HADDR, ldr_HWDATA;
  logic [1:0]  ldr_HTRANS;
  logic [2:0]  ldr_HSIZE;
  logic [31:0] s_HADDR, s_HWDATA, s_HRDATA;
  logic [1:0]  s_HTRANS;
  logic        s_HWRITE, s_HMASTLOCK, s_HREADY, s_HRESP;
  logic [2:0]  s_HSIZE, s_HBURST;
  logic [3:0]  s_HPROT;
  int tests = 0, fails = 0, n44 = 0;

  mfp_ahb_loader_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cpu_HADDR(cpu_HADDR), .cpu_HTRANS(cpu_HTRANS), .cpu_HWRITE(cpu_HWRITE), .cpu_HSIZE(cpu_HSIZE),
    .cpu_HBURST(cpu_HBURST), .cpu_HPROT(cpu_HPROT), .cpu_HMASTLOCK(cpu_HMASTLOCK), .cpu_HWDATA(cpu_HWDATA),
    .cpu_HRDATA(cpu_HRDATA), .cpu_HREADY(cpu_HREADY), .cpu_HRESP(cpu_HRESP),
    .ldr_req(ldr_req), .ldr_HADDR(ldr_HADDR), .ldr_HTRANS(ldr_HTRANS), .ldr_HWRITE(ldr_HWRITE),
    .ldr_HSIZE(ldr_HSIZE), .ldr_HWDATA(ldr_HWDATA), .ldr_HREADY(ldr_HREADY),
    .s_HADDR(s_HADDR), .s_HTRANS(s_HTRANS), .s_HWRITE(s_HWRITE), .s_HSIZE(s_HSIZE), .s_HBURST(s_HBURST),
    .s_HPROT(s_HPROT), .s_HMASTLOCK(s_HMASTLOCK), .s_HWDATA(s_HWDATA),
    .s_HRDATA(s_HRDATA), .s_HREADY(s_HREADY), .s_HRESP(s_HRESP), .ldr_granted(ldr_granted)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) if (s_HREADY && s_HTRANS[1] && s_HADDR == 32'h44) n44++;

  task automatic idle_all();
    cpu_HTRANS = 2'b00; cpu_HMASTLOCK = 1'b0; cpu_HWRITE = 1'b0; cpu_HBURST = 3'b000;
    ldr_req = 1'b0; ldr_HTRANS = 2'b00; s_HREADY = 1'b1; s_HRESP = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    cpu_HADDR = 0; cpu_HWDATA = 0; cpu_HSIZE = 3'd2; cpu_HPROT = 4'b0011;
    ldr_HADDR = 0; ldr_HWDATA = 0; ldr_HWRITE = 1'b0; ldr_HSIZE = 3'd0; s_HRDATA = 0;
    idle_all();
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    tests++; if (ldr_granted !== 1'b0) begin fails++; $display("FAIL rst_granted got=%b exp=0", ldr_granted); end
    tests++; if (cpu_HREADY !== 1'b1) begin fails++; $display("FAIL rst_cpu_ready got=%b exp=1", cpu_HREADY); end
    tests++; if (ldr_HREADY !== 1'b0) begin fails++; $display("FAIL rst_ldr_ready got=%b exp=0", ldr_HREADY); end
    tests++; if (s_HMASTLOCK !== 1'b0) begin fails++; $display("FAIL rst_mastlock got=%b exp=0", s_HMASTLOCK); end
  endtask

  task automatic test_passthru();
    @(negedge HCLK);
    cpu_HADDR = 32'h10; cpu_HTRANS = 2'b10; cpu_HWRITE = 1'b1; #1;
    tests++; if (s_HADDR !== 32'h10) begin fails++; $display("FAIL pt_addr got=%h exp=00000010", s_HADDR); end
    tests++; if (s_HTRANS !== 2'b10 || s_HWRITE !== 1'b1) begin fails++; $display("FAIL pt_ctrl got=%b/%b exp=10/1", s_HTRANS, s_HWRITE); end
    @(negedge HCLK);
    cpu_HTRANS = 2'b00; cpu_HWRITE = 1'b0; cpu_HWDATA = 32'h1234_5678; #1;
    tests++; if (s_HWDATA !== 32'h1234_5678) begin fails++; $display("FAIL pt_wdata got=%h exp=12345678", s_HWDATA); end
    tests++; if (cpu_HREADY !== 1'b1 || ldr_granted !== 1'b0) begin fails++; $display("FAIL pt_ready_gnt got=%b/%b exp=1/0", cpu_HREADY, ldr_granted); end
  endtask

  task automatic test_handover();
    @(negedge HCLK);
    cpu_HADDR = 32'h40; cpu_HTRANS = 2'b10; cpu_HWRITE = 1'b0;
    ldr_req = 1'b1; ldr_HADDR = 32'h100; ldr_HTRANS = 2'b10; ldr_HWRITE = 1'b1; ldr_HSIZE = 3'd0; #1;
    tests++; if (s_HADDR !== 32'h40 || ldr_granted !== 1'b0) begin fails++; $display("FAIL ho_cpu_addr got=%h/%b exp=00000040/0", s_HADDR, ldr_granted); end
    tests++; if (ldr_HREADY !== 1'b0) begin fails++; $display("FAIL ho_ldr_wait got=%b exp=0", ldr_HREADY); end
    @(negedge HCLK);
    cpu_HADDR = 32'h44; s_HRDATA = 32'hAAAA_0040; #1;
    tests++; if (ldr_granted !== 1'b1) begin fails++; $display("FAIL ho_granted got=%b exp=1", ldr_granted); end
    tests++; if (s_HADDR !== 32'h100 || s_HTRANS !== 2'b10 || s_HSIZE !== 3'd0) begin fails++; $display("FAIL ho_ldr_addr got=%h/%b/%d exp=00000100/10/0", s_HADDR, s_HTRANS, s_HSIZE); end
    tests++; if (s_HPROT !== 4'b0011 || s_HBURST !== 3'b000) begin fails++; $display("FAIL ho_ldr_prot got=%b/%b exp=0011/000", s_HPROT, s_HBURST); end
    tests++; if (cpu_HREADY !== 1'b1 || cpu_HRDATA !== 32'hAAAA_0040) begin fails++; $display("FAIL ho_cpu_rd got=%b/%h exp=1/aaaa0040", cpu_HREADY, cpu_HRDATA); end
    tests++; if (ldr_HREADY !== 1'b1) begin fails++; $display("FAIL ho_ldr_ready got=%b exp=1", ldr_HREADY); end
    @(negedge HCLK);
    cpu_HADDR = 32'h48; cpu_HTRANS = 2'b00; ldr_HTRANS = 2'b00; ldr_req = 1'b0; ldr_HWDATA = 32'h5A; #1;
    tests++; if (cpu_HREADY !== 1'b0) begin fails++; $display("FAIL ho_cpu_stall got=%b exp=0", cpu_HREADY); end
    tests++; if (s_HWDATA !== 32'h5A) begin fails++; $display("FAIL ho_ldr_wdata got=%h exp=0000005a", s_HWDATA); end
    tests++; if (dut.park_valid !== 1'b1) begin fails++; $display("FAIL ho_parked got=%b exp=1", dut.park_valid); end
    @(negedge HCLK);
    #1;
    tests++; if (s_HADDR !== 32'h44 || s_HTRANS !== 2'b10 || s_HWRITE !== 1'b0) begin fails++; $display("FAIL rp_addr got=%h/%b/%b exp=00000044/10/0", s_HADDR, s_HTRANS, s_HWRITE); end
    tests++; if (ldr_granted !== 1'b0 || cpu_HREADY !== 1'b0) begin fails++; $display("FAIL rp_gnt_ready got=%b/%b exp=0/0", ldr_granted, cpu_HREADY); end
    @(negedge HCLK);
    s_HRDATA = 32'hBBBB_0044; #1;
    tests++; if (cpu_HREADY !== 1'b1 || cpu_HRDATA !== 32'hBBBB_0044) begin fails++; $display("FAIL rp_cpu_rd got=%b/%h exp=1/bbbb0044", cpu_HREADY, cpu_HRDATA); end
    tests++; if (s_HADDR !== 32'h48 || s_HTRANS !== 2'b00) begin fails++; $display("FAIL rp_live got=%h/%b exp=00000048/00", s_HADDR, s_HTRANS); end
    tests++; if (dut.park_valid !== 1'b0 || ldr_HREADY !== 1'b0) begin fails++; $display("FAIL rp_clear got=%b/%b exp=0/0", dut.park_valid, ldr_HREADY); end
    tests++; if (n44 !== 1) begin fails++; $display("FAIL rp_no_dup got=%0d exp=1", n44); end
  endtask

  task automatic test_wait_states();
    @(negedge HCLK);
    cpu_HADDR = 32'h80; cpu_HTRANS = 2'b10; ldr_req = 1'b1; ldr_HADDR = 32'h200; ldr_HTRANS = 2'b10;
    @(negedge HCLK);
    cpu_HADDR = 32'h84; s_HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (cpu_HREADY !== 1'b0 || ldr_HREADY !== 1'b0 || s_HADDR !== 32'h200) begin fails++; $display("FAIL ws_hold%0d got=%b/%b/%h exp=0/0/00000200", i, cpu_HREADY, ldr_HREADY, s_HADDR); end
      tests++; if (dut.park_valid !== 1'b0) begin fails++; $display("FAIL ws_nopark%0d got=%b exp=0", i, dut.park_valid); end
      @(negedge HCLK);
    end
    s_HREADY = 1'b1; #1;
    tests++; if (cpu_HREADY !== 1'b1 || s_HADDR !== 32'h200) begin fails++; $display("FAIL ws_release got=%b/%h exp=1/00000200", cpu_HREADY, s_HADDR); end
    @(negedge HCLK);
    cpu_HTRANS = 2'b00; ldr_req = 1'b0; ldr_HTRANS = 2'b00; #1;
    tests++; if (dut.park_valid !== 1'b1 || cpu_HREADY !== 1'b0) begin fails++; $display("FAIL ws_parked got=%b/%b exp=1/0", dut.park_valid, cpu_HREADY); end
    @(negedge HCLK); #1;
    tests++; if (s_HADDR !== 32'h84) begin fails++; $display("FAIL ws_replay got=%h exp=00000084", s_HADDR); end
    @(negedge HCLK); #1;
    tests++; if (ldr_granted !== 1'b0 || cpu_HREADY !== 1'b1) begin fails++; $display("FAIL ws_back got=%b/%b exp=0/1", ldr_granted, cpu_HREADY); end
  endtask

  task automatic test_seq_rewrite();
    @(negedge HCLK);
    cpu_HADDR = 32'hC4; cpu_HTRANS = 2'b11; cpu_HBURST = 3'b011; ldr_req = 1'b1; ldr_HADDR = 32'h300; ldr_HTRANS = 2'b10;
    @(negedge HCLK);
    cpu_HADDR = 32'hC8; #1;
    tests++; if (s_HADDR !== 32'h300) begin fails++; $display("FAIL sq_ldr got=%h exp=00000300", s_HADDR); end
    @(negedge HCLK);
    cpu_HTRANS = 2'b00; ldr_req = 1'b0; ldr_HTRANS = 2'b00;
    @(negedge HCLK); #1;
    tests++; if (s_HADDR !== 32'hC8 || s_HTRANS !== 2'b10) begin fails++; $display("FAIL sq_rewrite got=%h/%b exp=000000c8/10", s_HADDR, s_HTRANS); end
    @(negedge HCLK);
    idle_all();
  endtask

  task automatic test_lock();
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      cpu_HADDR = 32'h400 + 32'(4 * i); cpu_HTRANS = 2'b10; cpu_HMASTLOCK = 1'b1;
      ldr_req = 1'b1; ldr_HADDR = 32'h800; ldr_HTRANS = 2'b10; #1;
      tests++; if (ldr_granted !== (LOCK ? 1'b0 : (i > 0))) begin fails++; $display("FAIL lk_gnt%0d got=%b exp=%b", i, ldr_granted, LOCK ? 1'b0 : (i > 0)); end
      tests++; if (s_HMASTLOCK !== LOCK) begin fails++; $display("FAIL lk_fwd%0d got=%b exp=%b", i, s_HMASTLOCK, LOCK); end
    end
    @(negedge HCLK);
    cpu_HMASTLOCK = 1'b0; cpu_HTRANS = 2'b00;
    @(negedge HCLK); #1;
    tests++; if (ldr_granted !== 1'b1) begin fails++; $display("FAIL lk_release got=%b exp=1", ldr_granted); end
    ldr_req = 1'b0; ldr_HTRANS = 2'b00;
    repeat (3) @(negedge HCLK);
    #1;
    tests++; if (ldr_granted !== 1'b0 || cpu_HREADY !== 1'b1) begin fails++; $display("FAIL lk_back got=%b/%b exp=0/1", ldr_granted, cpu_HREADY); end
  endtask

  task automatic test_reset_mid();
    @(negedge HCLK);
    cpu_HADDR = 32'h500; cpu_HTRANS = 2'b10; ldr_req = 1'b1; ldr_HADDR = 32'h700; ldr_HTRANS = 2'b10;
    @(negedge HCLK);
    cpu_HADDR = 32'h504;
    @(negedge HCLK);
    #1;
    tests++; if (dut.park_valid !== 1'b1 || ldr_granted !== 1'b1) begin fails++; $display("FAIL rm_setup got=%b/%b exp=1/1", dut.park_valid, ldr_granted); end
    #1 HRESET = 1'b1;
    #1;
    tests++; if (ldr_granted !== 1'b0 || dut.park_valid !== 1'b0) begin fails++; $display("FAIL rm_async got=%b/%b exp=0/0", ldr_granted, dut.park_valid); end
    #1 HRESET = 1'b0;
    cpu_HADDR = 32'h600; ldr_req = 1'b0; ldr_HTRANS = 2'b00; #1;
    tests++; if (s_HADDR !== 32'h600 || s_HTRANS !== 2'b10) begin fails++; $display("FAIL rm_live got=%h/%b exp=00000600/10", s_HADDR, s_HTRANS); end
    @(negedge HCLK); #1;
    tests++; if (cpu_HREADY !== 1'b1 || ldr_granted !== 1'b0) begin fails++; $display("FAIL rm_after got=%b/%b exp=1/0", cpu_HREADY, ldr_granted); end
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_handover();
    test_wait_states();
    test_seq_rewrite();
    test_lock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
